scu_dsp_dma_engine: RTL and testbench
=====================================

// Module: scu_dsp_dma_engine
// PURPOSE
// Parametrised DMA engine for the SCU DSP: moves COUNT words between the DSP data-RAM banks and the
// external A/B-bus, in either direction, with programmable address stride, hold mode and multi-bank fan-out.
// It replaces the fixed 4-bank/8-bit-count inline DMA logic. Adds abort, zero-count handling and a
// completion pulse. Sits between the DSP core (owns CT counters and RA0/WA0) and the SCU bus arbiter.
// PARAMETERS
// NBANK   4   number of data-RAM banks (>=2, power of 2)
// DW      32  data word width
// EAW     25  external word-address width
// CNTW    8   transfer-count width
// PORTS
// CLK        in   1           system clock
// RST_N      in   1           asynchronous active-low reset
// CE_R       in   1           clock enable; all state advances only when high
// START      in   1           begin transfer (sampled in IDLE only)
// ABORT      in   1           cancel current transfer
// DIR        in   1           0: ext->RAM, 1: RAM->ext
// HOLD       in   1           1: ADDR_OUT not updated (EXT_A still steps)
// ADDI       in   3           stride code
// BANK_MASK  in   NBANK       banks written on ext->RAM beats (multi-bank fan-out)
// BANK_SEL   in   $clog2(NBANK) source bank for RAM->ext
// COUNT      in   CNTW        number of words
// START_A    in   EAW         initial external word address
// RAM_Q      in   NBANK*DW    bank read data, 1-cycle sync-RAM latency, bank i at [i*DW +: DW]
// RAM_D      out  DW          bank write data
// RAM_WE     out  NBANK       bank write strobes
// CT_INC     out  NBANK       per-bank CT counter increment strobes
// EXT_A      out  EAW         external address
// EXT_DO     out  DW          external write data
// EXT_DI     in   DW          external read data
// EXT_WR     out  1           =latched DIR
// EXT_REQ    out  1           beat request
// EXT_ACK    in   1           beat accepted/data valid
// ADDR_OUT   out  EAW         write-back address for RA0/WA0
// BUSY       out  1           transfer in progress
// DONE       out  1           one-CE pulse on normal completion
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; latched DIR/HOLD/ADDI/mask/sel/count cleared.
// - Stride (words): ADDI==0 -> 0, else 1<<(ADDI-1) (0,1,2,4..64). EXT_A/ADDR_OUT wrap mod 2^EAW.
// - States: IDLE, FETCH, XFER, FIN.
// - IDLE: START&&!ABORT&&CE_R latches all controls, EXT_A=ADDR_OUT=START_A, remaining=COUNT, BUSY=1.
//   COUNT==0 -> FIN (no beat). DIR=0 -> XFER; DIR=1 -> FETCH. START while BUSY ignored.
// - FETCH (DIR=1): EXT_REQ=0, one CE cycle for RAM_Q of BANK_SEL to become valid -> XFER.
// - XFER: EXT_REQ=1. Beat completes on EXT_REQ&&EXT_ACK&&CE_R:
//   DIR=0: RAM_D=EXT_DI, RAM_WE=CT_INC=BANK_MASK combinationally in the ack cycle (1 word/CE max).
//   DIR=1: EXT_DO=RAM_Q[BANK_SEL] held stable while REQ; CT_INC one-hot BANK_SEL; next state FETCH
//   (1 word per 2 CE max, sync-RAM refetch).
//   Every beat: EXT_A+=stride; ADDR_OUT+=stride unless HOLD; remaining-=1; remaining hits 0 -> FIN.
// - FIN: DONE=1 one CE cycle, BUSY=0 next cycle, -> IDLE. ADDR_OUT holds final value until next START.
// - ABORT (any non-IDLE state, CE_R): -> IDLE, no DONE, no beat that cycle even if ACK also high
//   (ABORT wins), ADDR_OUT keeps count of completed beats. ABORT with START in IDLE: no start.
// - EXT_ACK outside XFER ignored; RAM_WE/CT_INC never asserted outside an acked XFER beat.
// - Async reset mid-transfer: immediate IDLE, outputs 0; no DONE.
// STRUCTURE
// - SCUDSP_PKG: DMAState_t enum; function DMAStride(ADDI) returning word stride.
// - One sub-module: scu_dsp_dma_addr_gen (EXT_A/ADDR_OUT registers, stride add, HOLD, wrap).
// - FSM, count, bank muxing in the top module; no RAM inside.
// TESTING
// - ext->RAM: COUNT=3, ADDI=1, START_A=0x100, mask=4'b0101, ACK every cycle -> 3 beats, EXT_A 100,101,102,
//   RAM_WE=0101 x3, CT_INC x3, ADDR_OUT=0x103, DONE 1 cycle after last ack.
// - RAM->ext: COUNT=2, BANK_SEL=2, ADDI=3 -> REQ alternates FETCH/XFER, EXT_DO=bank2 words, EXT_A 0,4; ADDR_OUT=8.
// - HOLD=1, COUNT=4, ADDI=2 -> EXT_A steps 0,2,4,6; ADDR_OUT stays START_A; DONE asserted.
// - COUNT=0 -> no EXT_REQ, DONE pulses 1 cycle after START, BUSY 1 for exactly 2 CE cycles.
// - ABORT with ACK on beat 2 of 5 -> no RAM_WE that cycle, ADDR_OUT=START_A+1, no DONE, IDLE; new START accepted.
// - CE_R low half the cycles with ACK stalls and RST_N pulse mid-transfer -> no beats lost/duplicated; reset -> outputs 0.

Source files
------------

// File: rtl/scu_dsp_dma_engine_pkg.sv
// Shared types and helpers for the SCU DSP DMA engine.
package scu_dsp_dma_engine_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StXfer, StFin} dma_state_e;

  // ADDI code to word stride: 0 -> 0, n -> 1 << (n-1)
  function automatic logic [6:0] dma_stride(input logic [2:0] addi);
    logic [6:0] s;
    if (addi == 3'd0) s = 7'd0;
    else              s = 7'd1 << (addi - 3'd1);
    return s;
  endfunction

endpackage

// File: rtl/scu_dsp_dma_addr_gen.sv
// External and write-back address registers for the DMA engine; both wrap mod 2^EAW.
module scu_dsp_dma_addr_gen
  import scu_dsp_dma_engine_pkg::*;
#(
  parameter int unsigned EAW = 25
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           load,
  input  logic           step,
  input  logic           hold,
  input  logic [2:0]     addi,
  input  logic [EAW-1:0] start_a,
  output logic [EAW-1:0] ext_a,
  output logic [EAW-1:0] addr_out
);

  logic [EAW-1:0] stride;
  logic [EAW-1:0] ext_a_q, addr_out_q;

  assign stride = EAW'(dma_stride(addi));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ext_a_q    <= '0;
      addr_out_q <= '0;
    end else if (load) begin
      ext_a_q    <= start_a;
      addr_out_q <= start_a;
    end else if (step) begin
      ext_a_q <= ext_a_q + stride;
      if (!hold) addr_out_q <= addr_out_q + stride;
    end
  end

  assign ext_a    = ext_a_q;
  assign addr_out = addr_out_q;

endmodule

// File: rtl/scu_dsp_dma_engine.sv
// DMA engine moving COUNT words between DSP data-RAM banks and the external A/B-bus.
module scu_dsp_dma_engine
  import scu_dsp_dma_engine_pkg::*;
#(
  parameter int unsigned NBANK = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned EAW   = 25,
  parameter int unsigned CNTW  = 8,
  localparam int unsigned SELW = $clog2(NBANK)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              START,
  input  logic              ABORT,
  input  logic              DIR,
  input  logic              HOLD,
  input  logic [2:0]        ADDI,
  input  logic [NBANK-1:0]  BANK_MASK,
  input  logic [SELW-1:0]   BANK_SEL,
  input  logic [CNTW-1:0]   COUNT,
  input  logic [EAW-1:0]    START_A,
  input  logic [NBANK*DW-1:0] RAM_Q,
  output logic [DW-1:0]     RAM_D,
  output logic [NBANK-1:0]  RAM_WE,
  output logic [NBANK-1:0]  CT_INC,
  output logic [EAW-1:0]    EXT_A,
  output logic [DW-1:0]     EXT_DO,
  input  logic [DW-1:0]     EXT_DI,
  output logic              EXT_WR,
  output logic              EXT_REQ,
  input  logic              EXT_ACK,
  output logic [EAW-1:0]    ADDR_OUT,
  output logic              BUSY,
  output logic              DONE
);

  dma_state_e       state_q, state_d;
  logic             dir_q, hold_q;
  logic [2:0]       addi_q;
  logic [NBANK-1:0] mask_q;
  logic [SELW-1:0]  sel_q;
  logic [CNTW-1:0]  rem_q;

  logic             start_go, beat;
  logic [DW-1:0]    sel_word;
  logic [NBANK-1:0] sel_onehot;

  assign start_go = (state_q == StIdle) && START && !ABORT && CE_R;
  // ABORT suppresses any beat in the same cycle
  assign beat     = (state_q == StXfer) && EXT_ACK && CE_R && !ABORT;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (SELW'(i) == sel_q) sel_word = RAM_Q[i*DW +: DW];
    end
  end

  assign sel_onehot = NBANK'(1) << sel_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_go) begin
          if (COUNT == '0) state_d = StFin;
          else if (DIR)    state_d = StFetch;
          else             state_d = StXfer;
        end
      end
      StFetch: begin
        if (CE_R) state_d = ABORT ? StIdle : StXfer;
      end
      StXfer: begin
        if (CE_R && ABORT) begin
          state_d = StIdle;
        end else if (beat) begin
          if (rem_q == CNTW'(1)) state_d = StFin;
          else if (dir_q)        state_d = StFetch;
          else                   state_d = StXfer;
        end
      end
      StFin: begin
        if (CE_R) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      hold_q  <= 1'b0;
      addi_q  <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
    end else if (CE_R) begin
      state_q <= state_d;
      if (start_go) begin
        dir_q  <= DIR;
        hold_q <= HOLD;
        addi_q <= ADDI;
        mask_q <= BANK_MASK;
        sel_q  <= BANK_SEL;
        rem_q  <= COUNT;
      end else if (beat) begin
        rem_q <= rem_q - CNTW'(1);
      end
    end
  end

  scu_dsp_dma_addr_gen #(
    .EAW (EAW)
  ) u_addr_gen (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (start_go),
    .step     (beat),
    .hold     (hold_q),
    .addi     (addi_q),
    .start_a  (START_A),
    .ext_a    (EXT_A),
    .addr_out (ADDR_OUT)
  );

  assign EXT_REQ = (state_q == StXfer);
  assign EXT_WR  = dir_q;
  assign RAM_D   = (EXT_REQ && !dir_q) ? EXT_DI : '0;
  // RAM_Q is stable while REQ because CT only moves on an acked beat
  assign EXT_DO  = (EXT_REQ && dir_q) ? sel_word : '0;
  assign RAM_WE  = (beat && !dir_q) ? mask_q : '0;
  assign CT_INC  = beat ? (dir_q ? sel_onehot : mask_q) : '0;
  assign BUSY    = (state_q != StIdle) || start_go;
  assign DONE    = (state_q == StFin) && !ABORT;

endmodule

// File: tb/tb_scu_dsp_dma_engine.sv
// Directed, table-driven bench for scu_dsp_dma_engine with a small bank/CT model.
module tb_scu_dsp_dma_engine;

  logic         CLK = 1'b0;
  logic         RST_N, CE_R, START, ABORT, DIR, HOLD;
  logic [2:0]   ADDI;
  logic [3:0]   BANK_MASK;
  logic [1:0]   BANK_SEL;
  logic [7:0]   COUNT;
  logic [24:0]  START_A;
  logic [127:0] RAM_Q;
  logic [31:0]  RAM_D;
  logic [3:0]   RAM_WE, CT_INC;
  logic [24:0]  EXT_A, ADDR_OUT;
  logic [31:0]  EXT_DO, EXT_DI;
  logic         EXT_WR, EXT_REQ, EXT_ACK, BUSY, DONE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  scu_dsp_dma_engine dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .START(START), .ABORT(ABORT), .DIR(DIR),
    .HOLD(HOLD), .ADDI(ADDI), .BANK_MASK(BANK_MASK), .BANK_SEL(BANK_SEL), .COUNT(COUNT),
    .START_A(START_A), .RAM_Q(RAM_Q), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .CT_INC(CT_INC),
    .EXT_A(EXT_A), .EXT_DO(EXT_DO), .EXT_DI(EXT_DI), .EXT_WR(EXT_WR), .EXT_REQ(EXT_REQ),
    .EXT_ACK(EXT_ACK), .ADDR_OUT(ADDR_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  // Bank model: word of bank b at CT position k
  function automatic logic [31:0] word(input int b, input int k);
    return 32'hD000_0000 | (32'(b) << 12) | 32'(k);
  endfunction

  logic [7:0] ct [4];
  logic       ct_clr = 1'b0;

  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (ct_clr) ct[i] <= 8'd0;
      else        ct[i] <= ct[i] + {7'd0, CT_INC[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) RAM_Q[i*32 +: 32] = word(i, int'(ct[i]));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        dir;
    logic        hold;
    logic [2:0]  addi;
    logic [3:0]  mask;
    logic [1:0]  sel;
    logic [7:0]  count;
    logic [24:0] start_a;
    logic [24:0] step;
    logic [24:0] exp_addr;
    int          exp_done_c;
  } vec_t;

  vec_t tbl [6];

  task automatic clr_ct();
    ct_clr = 1'b1;
    @(posedge CLK);
    #1 ct_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit stall);
    int beats;
    int dones;
    logic [24:0] ea;
    clr_ct();
    DIR = v.dir; HOLD = v.hold; ADDI = v.addi; BANK_MASK = v.mask; BANK_SEL = v.sel;
    COUNT = v.count; START_A = v.start_a; CE_R = 1'b1; EXT_ACK = 1'b1; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    beats = 0; dones = 0; ea = v.start_a;
    for (int c = 1; c < 200 && dones == 0; c++) begin
      if (stall) begin
        CE_R    = 1'($urandom_range(0, 1));
        EXT_ACK = 1'($urandom_range(0, 1));
      end
      EXT_DI = 32'hE000_0000 | 32'(c);
      @(negedge CLK);
      if (EXT_REQ && EXT_ACK && CE_R) begin
        chk("beat_ext_a", 64'(EXT_A), 64'(ea));
        chk("beat_ram_we", 64'(RAM_WE), v.dir ? 64'd0 : 64'(v.mask));
        chk("beat_ct_inc", 64'(CT_INC), v.dir ? (64'd1 << v.sel) : 64'(v.mask));
        if (v.dir) chk("beat_ext_do", 64'(EXT_DO), 64'(word(int'(v.sel), beats)));
        else       chk("beat_ram_d", 64'(RAM_D), 64'(EXT_DI));
        chk("beat_ext_wr", 64'(EXT_WR), 64'(v.dir));
        ea = ea + v.step;
        beats++;
      end else begin
        chk("idle_strobes", 64'({RAM_WE, CT_INC}), 64'd0);
      end
      if (DONE && CE_R) begin
        dones++;
        if (!stall) chk("done_cycle", 64'(c), 64'(v.exp_done_c));
      end
      @(posedge CLK);
      #1;
    end
    chk("beat_count", 64'(beats), 64'(v.count));
    chk("done_count", 64'(dones), 64'd1);
    chk("addr_out", 64'(ADDR_OUT), 64'(v.exp_addr));
    chk("busy_after", 64'(BUSY), 64'd0);
    CE_R = 1'b1; EXT_ACK = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; CE_R = 1'b1; START = 1'b0; ABORT = 1'b0; DIR = 1'b0; HOLD = 1'b0;
    ADDI = '0; BANK_MASK = '0; BANK_SEL = '0; COUNT = '0; START_A = '0; EXT_DI = '0;
    EXT_ACK = 1'b0;

    //          dir  hold addi mask     sel  count start_a        step     exp_addr    done_c
    tbl[0] = '{1'b0, 1'b0, 3'd1, 4'b0101, 2'd0, 8'd3, 25'h100,      25'd1,  25'h103,     4};
    tbl[1] = '{1'b1, 1'b0, 3'd3, 4'b0000, 2'd2, 8'd2, 25'h0,        25'd4,  25'h8,       5};
    tbl[2] = '{1'b0, 1'b1, 3'd2, 4'b1111, 2'd0, 8'd4, 25'h0,        25'd2,  25'h0,       5};
    tbl[3] = '{1'b0, 1'b0, 3'd1, 4'b0001, 2'd0, 8'd0, 25'h55,       25'd1,  25'h55,      1};
    tbl[4] = '{1'b0, 1'b0, 3'd1, 4'b1000, 2'd0, 8'd2, 25'h1FFFFFF,  25'd1,  25'h1,       3};
    tbl[5] = '{1'b1, 1'b0, 3'd7, 4'b0000, 2'd1, 8'd2, 25'h10,       25'd64, 25'h90,      5};

    #12;
    chk("rst_outputs", 64'({BUSY, DONE, EXT_REQ, EXT_WR, RAM_WE, CT_INC}), 64'd0);
    chk("rst_addr", 64'({EXT_A, ADDR_OUT}), 64'd0);
    chk("rst_data", 64'({RAM_D, EXT_DO}), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], 1'b0);

    // COUNT=0: BUSY high in the accepting cycle and the FIN cycle only
    clr_ct();
    COUNT = 8'd0; START_A = 25'h77; START = 1'b1;
    #1 chk("z_busy_c0", 64'({BUSY, EXT_REQ}), 64'b10);
    @(posedge CLK);
    #1 START = 1'b0;
    chk("z_c1", 64'({BUSY, DONE, EXT_REQ}), 64'b110);
    @(posedge CLK);
    #1 chk("z_c2", 64'({BUSY, DONE, EXT_REQ}), 64'b000);

    // START together with ABORT in IDLE does not start
    START = 1'b1; ABORT = 1'b1; COUNT = 8'd3;
    #1 chk("sa_busy", 64'(BUSY), 64'd0);
    @(posedge CLK);
    #1 START = 1'b0; ABORT = 1'b0;
    chk("sa_idle", 64'({BUSY, EXT_REQ}), 64'd0);

    // ABORT on beat 2 of 5 with ACK high
    clr_ct();
    DIR = 1'b0; HOLD = 1'b0; ADDI = 3'd1; BANK_MASK = 4'b0011; COUNT = 8'd5;
    START_A = 25'h20; START = 1'b1; EXT_ACK = 1'b0;
    @(posedge CLK);
    #1 START = 1'b0; EXT_ACK = 1'b1;
    @(negedge CLK);
    chk("ab_beat1_we", 64'(RAM_WE), 64'b0011);
    @(posedge CLK);
    #1 ABORT = 1'b1;
    @(negedge CLK);
    chk("ab_no_beat", 64'({RAM_WE, CT_INC, DONE}), 64'd0);
    @(posedge CLK);
    #1 ABORT = 1'b0;
    @(negedge CLK);
    chk("ab_idle", 64'({BUSY, EXT_REQ, DONE}), 64'd0);
    chk("ab_addr_out", 64'(ADDR_OUT), 64'h21);
    @(posedge CLK);
    #1;
    run_vec(tbl[0], 1'b0);

    // CE_R / ACK stalls must not lose or duplicate beats
    run_vec(tbl[0], 1'b1);
    run_vec(tbl[1], 1'b1);
    run_vec(tbl[2], 1'b1);

    // Asynchronous reset mid-transfer
    clr_ct();
    DIR = 1'b1; ADDI = 3'd1; BANK_SEL = 2'd3; COUNT = 8'd5; START_A = 25'h40;
    START = 1'b1; EXT_ACK = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("mrst_ctrl", 64'({BUSY, DONE, EXT_REQ, EXT_WR, RAM_WE, CT_INC}), 64'd0);
    chk("mrst_addr", 64'({EXT_A, ADDR_OUT}), 64'd0);
    chk("mrst_data", 64'({RAM_D, EXT_DO}), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    run_vec(tbl[5], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
